// File: rtl/gate_check_pkg.sv
// Shared types and the reference gate function for the quad gate checker.
// Expected response ordering is {y4,y3,y2,y1}.
package gate_check_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam int NUM_VECTORS = 8;

  function automatic logic [3:0] exp_resp(input logic [2:0] abc);
    logic a, b, c;
    {a, b, c} = abc;
    return {b | c, a & c, a | b, a & b};
  endfunction

endpackage

// File: rtl/gate_check_delay.sv
// LATENCY-stage shift register aligning expected data with DUT responses.
// LATENCY=0 is a plain wire.
module gate_check_delay #(
  parameter int LATENCY = 0,
  parameter int W       = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (LATENCY == 0) begin : g_thru
    assign q = d;
  end else begin : g_pipe
    logic [W-1:0] sr [LATENCY];

    always_ff @(posedge clk) begin
      if (!resetn) begin
        for (int i = 0; i < LATENCY; i++)
          sr[i] <= '0;
      end else begin
        sr[0] <= d;
        for (int i = 1; i < LATENCY; i++)
          sr[i] <= sr[i-1];
      end
    end

    assign q = sr[LATENCY-1];
  end

endmodule

// File: rtl/gate_quad_checker.sv
// Exhaustive stimulus/response checker for the quad AND/OR gate block.
// Optional first-mismatch capture: GATE_CHECK_FIRST_FAIL_EN.
module gate_quad_checker
  import gate_check_pkg::*;
#(
  parameter int LATENCY = 0,
  parameter int PASSES  = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       y1,
  input  logic       y2,
  input  logic       y3,
  input  logic       y4,
  output logic       stim_a,
  output logic       stim_b,
  output logic       stim_c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count
`ifdef GATE_CHECK_FIRST_FAIL_EN
  ,
  output logic       first_fail_valid,
  output logic [2:0] first_fail_vec,
  output logic [3:0] first_fail_y
`endif
);

  localparam logic [7:0] PASS_N = 8'(PASSES);
  localparam logic [2:0] LAST_V = 3'(NUM_VECTORS - 1);
  localparam logic [2:0] DRAIN_N = 3'(LATENCY - 1);
`ifdef GATE_CHECK_FIRST_FAIL_EN
  localparam int DW = 8;
`else
  localparam int DW = 5;
`endif

  state_t     state;
  logic [2:0] v;
  logic [7:0] pcnt;
  logic [2:0] dcnt;
  logic [2:0] stim;
  logic       stim_vld;

  logic [DW-1:0] dl_d;
  logic [DW-1:0] dl_q;
  logic          vld_q;
  logic [3:0]    exp_q;
  logic [3:0]    obs;
  logic          mis;
  logic [7:0]    err_nxt;

  assign {stim_a, stim_b, stim_c} = stim;

`ifdef GATE_CHECK_FIRST_FAIL_EN
  logic [2:0] vec_q;
  assign dl_d = {stim_vld, exp_resp(stim), stim};
  assign {vld_q, exp_q, vec_q} = dl_q;
`else
  assign dl_d = {stim_vld, exp_resp(stim)};
  assign {vld_q, exp_q} = dl_q;
`endif

  gate_check_delay #(
    .LATENCY(LATENCY),
    .W      (DW)
  ) u_delay (
    .clk   (clk),
    .resetn(resetn),
    .d     (dl_d),
    .q     (dl_q)
  );

  assign obs = {y4, y3, y2, y1};
  assign mis = vld_q && (obs != exp_q);
  assign err_nxt = (mis && err_count != 8'hff) ?
                   err_count + 8'd1 : err_count;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      v         <= '0;
      pcnt      <= '0;
      dcnt      <= '0;
      stim      <= '0;
      stim_vld  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
    end else begin
      done      <= 1'b0;
      err_count <= err_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            stim      <= '0;
            stim_vld  <= 1'b1;
            v         <= 3'd1;
            pcnt      <= '0;
            err_count <= '0;
            pass      <= 1'b0;
          end
        end
        RUN: begin
          // v has wrapped PASSES times: every vector is out
          if (v == '0 && pcnt == PASS_N) begin
            stim     <= '0;
            stim_vld <= 1'b0;
            if (LATENCY == 0) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_nxt == 8'd0);
            end else begin
              state <= DRAIN;
              dcnt  <= DRAIN_N;
            end
          end else begin
            stim <= v;
            v    <= v + 3'd1;
            if (v == LAST_V)
              pcnt <= pcnt + 8'd1;
          end
        end
        DRAIN: begin
          if (dcnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == 8'd0);
          end else begin
            dcnt <= dcnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GATE_CHECK_FIRST_FAIL_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
      first_fail_y     <= '0;
    end else if (state == IDLE && start) begin
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
      first_fail_y     <= '0;
    end else if (mis && !first_fail_valid) begin
      first_fail_valid <= 1'b1;
      first_fail_vec   <= vec_q;
      first_fail_y     <= obs;
    end
  end
`endif

endmodule
